ibex_trace_buffer: RTL and testbench

// - Captures retired-instruction records from the core's RVFI outputs into a Depth-entry record FIFO.
// - Serialises each record as 32-bit words onto a valid/ready trace stream.
// - Sits beside ibex_top in tracing builds: in-silicon successor to the simulation-only text tracer.
// - Adds capture filtering, one-shot freeze and drop accounting.

---
 rtl/ibex_trace_buffer.sv | 156 +++++++++++++++
 tb/tb_ibex_trace_buffer.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_trace_buffer.sv
// RVFI retirement capture FIFO serialised onto a 32-bit valid/ready trace stream.
// Optional capability words are enabled by defining CHERI_TRACE_CAP_EN.
module ibex_trace_buffer #(
   parameter int unsigned Depth = 16,
   parameter int unsigned CntW  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [1:0]                 cfg_mode_i,
   input  logic                       cfg_clear_i,
   input  logic                       rvfi_valid_i,
   input  logic [63:0]                rvfi_order_i,
   input  logic                       rvfi_trap_i,
   input  logic                       rvfi_intr_i,
   input  logic [1:0]                 rvfi_mode_i,
   input  logic [4:0]                 rvfi_rd_addr_i,
   input  logic [31:0]                rvfi_rd_wdata_i,
   input  logic [31:0]                rvfi_pc_rdata_i,
   input  logic [31:0]                rvfi_insn_i,
   input  logic [31:0]                rvfi_mem_addr_i,
`ifdef CHERI_TRACE_CAP_EN
   input  logic                       rvfi_rd_wtag_i,
   input  logic [31:0]                rvfi_rd_wcap_hi_i,
`endif
   output logic                       trace_valid_o,
   input  logic                       trace_ready_i,
   output logic [31:0]                trace_data_o,
   output logic                       trace_last_o,
   output logic [$clog2(Depth+1)-1:0] level_o,
   output logic [CntW-1:0]            drop_cnt_o,
   output logic                       frozen_o
);

`ifdef CHERI_TRACE_CAP_EN
   localparam int unsigned NW = 7;
   localparam int unsigned RW = 193;
`else
   localparam int unsigned NW = 5;
   localparam int unsigned RW = 160;
`endif
   localparam int unsigned PW = $clog2(Depth);
   localparam int unsigned LW = $clog2(Depth+1);
   localparam logic [2:0] LastIdx = 3'(NW-1);

   localparam logic [1:0] ModeOff     = 2'b00;
   localparam logic [1:0] ModeTrap    = 2'b10;
   localparam logic [1:0] ModeOneShot = 2'b11;

   logic [RW-1:0] mem [Depth];
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [2:0]    word_idx;
   logic          ovf_pending;

   logic          empty;
   logic          full;
   logic          capture;
   logic          push;
   logic          word_fire;
   logic          pop;
   logic          drop_count;
   logic          fill_now;
   logic [31:0]   w0;
   logic [RW-1:0] wr_rec;
   logic [RW-1:0] head_rec;
   logic [31:0]   head_word;
   logic          unused_order;

   assign unused_order = ^rvfi_order_i[63:16];

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
   assign level_o = LW'(wr_ptr - rd_ptr);

   assign capture = rvfi_valid_i && (cfg_mode_i != ModeOff) && !frozen_o &&
                    ((cfg_mode_i != ModeTrap) || rvfi_trap_i || rvfi_intr_i);

   // Fullness is judged before any same-cycle pop; clear wins over everything.
   assign push       = capture && !full && !cfg_clear_i;
   assign drop_count = capture && full && !cfg_clear_i && (cfg_mode_i != ModeOneShot);
   assign word_fire  = trace_valid_o && trace_ready_i && !cfg_clear_i;
   assign pop        = word_fire && (word_idx == LastIdx);
   assign fill_now   = push && (cfg_mode_i == ModeOneShot) &&
                       (level_o == LW'(Depth-1)) && !pop;

   assign w0 = {rvfi_trap_i, rvfi_intr_i, ovf_pending, rvfi_mode_i, rvfi_rd_addr_i,
                6'b0, rvfi_order_i[15:0]};

`ifdef CHERI_TRACE_CAP_EN
   assign wr_rec = {rvfi_rd_wtag_i, rvfi_rd_wcap_hi_i, rvfi_mem_addr_i, rvfi_rd_wdata_i,
                    rvfi_insn_i, rvfi_pc_rdata_i, w0};
`else
   assign wr_rec = {rvfi_mem_addr_i, rvfi_rd_wdata_i, rvfi_insn_i, rvfi_pc_rdata_i, w0};
`endif

   assign head_rec = mem[rd_ptr[PW-1:0]];

   always_comb begin
      head_word = 32'h0;
      case (word_idx)
         3'd0:    head_word = head_rec[31:0];
         3'd1:    head_word = head_rec[63:32];
         3'd2:    head_word = head_rec[95:64];
         3'd3:    head_word = head_rec[127:96];
         3'd4:    head_word = head_rec[159:128];
`ifdef CHERI_TRACE_CAP_EN
         3'd5:    head_word = head_rec[191:160];
         3'd6:    head_word = {31'b0, head_rec[192]};
`endif
         default: head_word = 32'h0;
      endcase
   end

   assign trace_valid_o = !empty;
   assign trace_data_o  = empty ? 32'h0 : head_word;
   assign trace_last_o  = !empty && (word_idx == LastIdx);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr[PW-1:0]] <= wr_rec;
      end
   end

   // Reset and clear share one path: both abandon any record mid-serialisation.
   always_ff @(posedge clk_i) begin
      if (rst_i || cfg_clear_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         word_idx    <= '0;
         drop_cnt_o  <= '0;
         ovf_pending <= 1'b0;
         frozen_o    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr      <= wr_ptr + {{PW{1'b0}}, 1'b1};
            ovf_pending <= 1'b0;
         end
         if (fill_now) begin
            frozen_o <= 1'b1;
         end
         if (drop_count) begin
            ovf_pending <= 1'b1;
            if (drop_cnt_o != {CntW{1'b1}}) begin
               drop_cnt_o <= drop_cnt_o + {{(CntW-1){1'b0}}, 1'b1};
            end
         end
         if (word_fire) begin
            word_idx <= pop ? 3'd0 : word_idx + 3'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_ibex_trace_buffer.sv
// Randomised testbench for ibex_trace_buffer with a queue-of-words reference model.
// Define CHERI_TRACE_CAP_EN to also exercise the capability words.
`timescale 1ns/1ps
module tb_ibex_trace_buffer;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH+1);
`ifdef CHERI_TRACE_CAP_EN
   localparam int NW = 7;
`else
   localparam int NW = 5;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  cfg_mode_i;
   logic        cfg_clear_i;
   logic        rvfi_valid_i;
   logic [63:0] rvfi_order_i;
   logic        rvfi_trap_i;
   logic        rvfi_intr_i;
   logic [1:0]  rvfi_mode_i;
   logic [4:0]  rvfi_rd_addr_i;
   logic [31:0] rvfi_rd_wdata_i;
   logic [31:0] rvfi_pc_rdata_i;
   logic [31:0] rvfi_insn_i;
   logic [31:0] rvfi_mem_addr_i;
   logic        rvfi_rd_wtag_i;
   logic [31:0] rvfi_rd_wcap_hi_i;
   logic        trace_valid_o;
   logic        trace_ready_i;
   logic [31:0] trace_data_o;
   logic        trace_last_o;
   logic [LW-1:0] level_o;
   logic [15:0] drop_cnt_o;
   logic        frozen_o;

   always #5 clk_i = ~clk_i;

   ibex_trace_buffer #(.Depth(DEPTH), .CntW(16)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .cfg_mode_i(cfg_mode_i),
      .cfg_clear_i(cfg_clear_i),
      .rvfi_valid_i(rvfi_valid_i),
      .rvfi_order_i(rvfi_order_i),
      .rvfi_trap_i(rvfi_trap_i),
      .rvfi_intr_i(rvfi_intr_i),
      .rvfi_mode_i(rvfi_mode_i),
      .rvfi_rd_addr_i(rvfi_rd_addr_i),
      .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
      .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
      .rvfi_insn_i(rvfi_insn_i),
      .rvfi_mem_addr_i(rvfi_mem_addr_i),
`ifdef CHERI_TRACE_CAP_EN
      .rvfi_rd_wtag_i(rvfi_rd_wtag_i),
      .rvfi_rd_wcap_hi_i(rvfi_rd_wcap_hi_i),
`endif
      .trace_valid_o(trace_valid_o),
      .trace_ready_i(trace_ready_i),
      .trace_data_o(trace_data_o),
      .trace_last_o(trace_last_o),
      .level_o(level_o),
      .drop_cnt_o(drop_cnt_o),
      .frozen_o(frozen_o)
   );

   int vectors = 0;
   int miscompares = 0;

   // Model: every stored record is a run of NW expected words; level is whole-or-partial records.
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   int  m_drop;
   bit  m_ovf;
   bit  m_frozen;

   function automatic int model_level();
      return (exp_q.size() + NW - 1) / NW;
   endfunction

   task automatic push_record();
      exp_q.push_back({rvfi_trap_i, rvfi_intr_i, m_ovf, rvfi_mode_i, rvfi_rd_addr_i,
                       6'b0, rvfi_order_i[15:0]});
      exp_q.push_back(rvfi_pc_rdata_i);
      exp_q.push_back(rvfi_insn_i);
      exp_q.push_back(rvfi_rd_wdata_i);
      exp_q.push_back(rvfi_mem_addr_i);
`ifdef CHERI_TRACE_CAP_EN
      exp_q.push_back(rvfi_rd_wcap_hi_i);
      exp_q.push_back({31'b0, rvfi_rd_wtag_i});
`endif
   endtask

   task automatic idle_inputs();
      rvfi_valid_i      = 1'b0;
      rvfi_order_i      = 64'h0;
      rvfi_trap_i       = 1'b0;
      rvfi_intr_i       = 1'b0;
      rvfi_mode_i       = 2'b00;
      rvfi_rd_addr_i    = 5'h0;
      rvfi_rd_wdata_i   = 32'h0;
      rvfi_pc_rdata_i   = 32'h0;
      rvfi_insn_i       = 32'h0;
      rvfi_mem_addr_i   = 32'h0;
      rvfi_rd_wtag_i    = 1'b0;
      rvfi_rd_wcap_hi_i = 32'h0;
   endtask

   task automatic random_fields();
      rvfi_order_i      = {$urandom, $urandom};
      rvfi_mode_i       = 2'($urandom);
      rvfi_rd_addr_i    = 5'($urandom);
      rvfi_rd_wdata_i   = $urandom;
      rvfi_pc_rdata_i   = $urandom;
      rvfi_insn_i       = $urandom;
      rvfi_mem_addr_i   = $urandom;
      rvfi_rd_wtag_i    = 1'($urandom);
      rvfi_rd_wcap_hi_i = $urandom;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic tick();
      int  lvl;
      bit  cap;
      bit  exp_valid;
      bit  exp_last;
      @(negedge clk_i);
      lvl       = model_level();
      exp_valid = exp_q.size() > 0;
      exp_last  = (exp_q.size() % NW) == 1;
      vectors++;
      if (trace_valid_o !== exp_valid) begin
         miscompares++;
         $display("[TB] FAIL valid: got %b expected %b", trace_valid_o, exp_valid);
      end
      if (exp_valid) begin
         vectors++;
         if (trace_data_o !== exp_q[0]) begin
            miscompares++;
            $display("[TB] FAIL data: got %08h expected %08h", trace_data_o, exp_q[0]);
         end
         vectors++;
         if (trace_last_o !== exp_last) begin
            miscompares++;
            $display("[TB] FAIL last: got %b expected %b", trace_last_o, exp_last);
         end
      end
      vectors++;
      if (level_o !== LW'(lvl)) begin
         miscompares++;
         $display("[TB] FAIL level: got %0d expected %0d", level_o, lvl);
      end
      vectors++;
      if (drop_cnt_o !== 16'(m_drop)) begin
         miscompares++;
         $display("[TB] FAIL drop_cnt: got %0d expected %0d", drop_cnt_o, m_drop);
      end
      vectors++;
      if (frozen_o !== m_frozen) begin
         miscompares++;
         $display("[TB] FAIL frozen: got %b expected %b", frozen_o, m_frozen);
      end
      if (trace_valid_o && trace_ready_i && !rst_i && !cfg_clear_i) begin
         obs_q.push_back(trace_data_o);
      end

      if (rst_i || cfg_clear_i) begin
         exp_q.delete();
         m_drop   = 0;
         m_ovf    = 1'b0;
         m_frozen = 1'b0;
      end else begin
         cap = rvfi_valid_i && (cfg_mode_i != 2'b00) && !m_frozen &&
               ((cfg_mode_i != 2'b10) || rvfi_trap_i || rvfi_intr_i);
         if (exp_valid && trace_ready_i) begin
            void'(exp_q.pop_front());
         end
         if (cap) begin
            if (lvl < DEPTH) begin
               push_record();
               m_ovf = 1'b0;
               if (cfg_mode_i == 2'b11 && model_level() == DEPTH) begin
                  m_frozen = 1'b1;
               end
            end else if (cfg_mode_i != 2'b11) begin
               if (m_drop < 65535) m_drop++;
               m_ovf = 1'b1;
            end
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic retire();
      rvfi_valid_i = 1'b1;
      tick();
      rvfi_valid_i = 1'b0;
   endtask

   task automatic clear_pulse();
      cfg_clear_i = 1'b1;
      tick();
      cfg_clear_i = 1'b0;
   endtask

   task automatic drain();
      trace_ready_i = 1'b1;
      for (int i = 0; i < 40 * NW * DEPTH && exp_q.size() > 0; i++) begin
         tick();
      end
      tick();
      vectors++;
      if (trace_valid_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL drain_empty: got valid=%b expected 0", trace_valid_o);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      cfg_mode_i    = 2'b00;
      cfg_clear_i   = 1'b0;
      trace_ready_i = 1'b0;
      rst_i         = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      exp_q.delete();
      obs_q.delete();
      m_drop = 0;
      m_ovf = 1'b0;
      m_frozen = 1'b0;
      vectors++;
      if ({trace_valid_o, trace_last_o, frozen_o} !== 3'b000 || trace_data_o !== 32'h0 ||
          level_o !== '0 || drop_cnt_o !== 16'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got valid=%b last=%b data=%08h level=%0d drop=%0d frozen=%b expected all 0",
                  trace_valid_o, trace_last_o, trace_data_o, level_o, drop_cnt_o, frozen_o);
      end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_single();
      obs_q.delete();
      cfg_mode_i      = 2'b01;
      trace_ready_i   = 1'b1;
      idle_inputs();
      rvfi_pc_rdata_i = 32'h8000_0000;
      rvfi_insn_i     = 32'h0000_0013;
      rvfi_order_i    = 64'd3;
      retire();
      idle_inputs();
      drain();
      vectors++;
      if (obs_q.size() != NW) begin
         miscompares++;
         $display("[TB] FAIL single_count: got %0d words expected %0d", obs_q.size(), NW);
      end else begin
         vectors++;
         if (obs_q[0] !== 32'h0000_0003 || obs_q[1] !== 32'h8000_0000 ||
             obs_q[2] !== 32'h0000_0013 || obs_q[3] !== 32'h0 || obs_q[4] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL single_words: got %08h %08h %08h %08h %08h expected 00000003 80000000 00000013 00000000 00000000",
                     obs_q[0], obs_q[1], obs_q[2], obs_q[3], obs_q[4]);
         end
      end
   endtask

   task automatic test_filter();
      int peak;
      peak = 0;
      obs_q.delete();
      cfg_mode_i    = 2'b10;
      trace_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         random_fields();
         rvfi_trap_i = (i == 2);
         rvfi_intr_i = 1'b0;
         retire();
         if (int'(level_o) > peak) peak = int'(level_o);
      end
      idle_inputs();
      vectors++;
      if (peak != 1) begin
         miscompares++;
         $display("[TB] FAIL filter_peak: got %0d expected 1", peak);
      end
      drain();
      vectors++;
      if (obs_q.size() != NW || obs_q[0][31] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL filter_record: got %0d words expected %0d with trap bit set", obs_q.size(), NW);
      end
   endtask

   task automatic test_overflow();
      clear_pulse();
      obs_q.delete();
      cfg_mode_i    = 2'b01;
      trace_ready_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         random_fields();
         rvfi_trap_i = 1'b0;
         rvfi_intr_i = 1'b0;
         retire();
      end
      idle_inputs();
      vectors++;
      if (level_o !== LW'(16) || drop_cnt_o !== 16'd4) begin
         miscompares++;
         $display("[TB] FAIL overflow_counts: got level=%0d drop=%0d expected 16 and 4", level_o, drop_cnt_o);
      end
      trace_ready_i = 1'b1;
      repeat (NW) tick();
      random_fields();
      retire();
      idle_inputs();
      drain();
      vectors++;
      if (obs_q.size() != 17 * NW) begin
         miscompares++;
         $display("[TB] FAIL overflow_total: got %0d words expected %0d", obs_q.size(), 17 * NW);
      end else begin
         vectors++;
         if (obs_q[16 * NW][29] !== 1'b1 || obs_q[0][29] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overflow_flag: got first=%b seventeenth=%b expected 0 and 1",
                     obs_q[0][29], obs_q[16 * NW][29]);
         end
      end
   endtask

   task automatic test_oneshot();
      clear_pulse();
      cfg_mode_i    = 2'b11;
      trace_ready_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         random_fields();
         rvfi_trap_i = 1'($urandom);
         rvfi_intr_i = 1'($urandom);
         retire();
         if (i == 14 || i == 15) begin
            vectors++;
            if (frozen_o !== (i == 15)) begin
               miscompares++;
               $display("[TB] FAIL oneshot_freeze_edge: after retire %0d got %b expected %b", i + 1, frozen_o, i == 15);
            end
         end
      end
      idle_inputs();
      vectors++;
      if (level_o !== LW'(16) || drop_cnt_o !== 16'd0 || frozen_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL oneshot_state: got level=%0d drop=%0d frozen=%b expected 16 0 1", level_o, drop_cnt_o, frozen_o);
      end
      clear_pulse();
      vectors++;
      if (level_o !== '0 || frozen_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL oneshot_clear: got level=%0d frozen=%b expected 0 0", level_o, frozen_o);
      end
      cfg_mode_i = 2'b01;
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      obs_q.delete();
      cfg_mode_i      = 2'b01;
      trace_ready_i   = 1'b0;
      idle_inputs();
      rvfi_pc_rdata_i = 32'h0000_1000;
      rvfi_insn_i     = 32'h0000_2000;
      rvfi_rd_wdata_i = 32'h0000_3000;
      rvfi_mem_addr_i = 32'h0000_4000;
      rvfi_order_i    = 64'd7;
      retire();
      idle_inputs();
      trace_ready_i = 1'b1;
      tick();
      trace_ready_i = 1'b0;
      held = trace_data_o;
      tick();
      tick();
      vectors++;
      if (trace_data_o !== held) begin
         miscompares++;
         $display("[TB] FAIL stall_hold: got %08h expected %08h", trace_data_o, held);
      end
      drain();
      vectors++;
      if (obs_q.size() != NW || obs_q[0] !== 32'h0000_0007 || obs_q[1] !== 32'h0000_1000 ||
          obs_q[2] !== 32'h0000_2000 || obs_q[3] !== 32'h0000_3000 || obs_q[4] !== 32'h0000_4000) begin
         miscompares++;
         $display("[TB] FAIL stall_order: got %0d words expected %0d in order 7,1000,2000,3000,4000", obs_q.size(), NW);
      end
   endtask

   task automatic test_midrecord_reset();
      cfg_mode_i    = 2'b01;
      trace_ready_i = 1'b0;
      random_fields();
      retire();
      random_fields();
      retire();
      idle_inputs();
      trace_ready_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      vectors++;
      if (trace_valid_o !== 1'b0 || level_o !== '0) begin
         miscompares++;
         $display("[TB] FAIL midrecord_reset: got valid=%b level=%0d expected 0 0", trace_valid_o, level_o);
      end
      tick();
   endtask

`ifdef CHERI_TRACE_CAP_EN
   task automatic test_cap();
      obs_q.delete();
      cfg_mode_i        = 2'b01;
      trace_ready_i     = 1'b1;
      random_fields();
      rvfi_rd_wtag_i    = 1'b1;
      rvfi_rd_wcap_hi_i = 32'hDEAD_BEEF;
      retire();
      idle_inputs();
      drain();
      vectors++;
      if (obs_q.size() != NW || obs_q[5] !== 32'hDEAD_BEEF || obs_q[6] !== 32'h0000_0001) begin
         miscompares++;
         $display("[TB] FAIL cap_words: got %0d words expected 7 ending DEADBEEF,00000001", obs_q.size());
      end
   endtask
`endif

   // Back-to-back retires, mode changes, clears and random backpressure.
   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         random_fields();
         rvfi_valid_i  = ($urandom_range(0, 3) != 0);
         rvfi_trap_i   = ($urandom_range(0, 5) == 0);
         rvfi_intr_i   = ($urandom_range(0, 7) == 0);
         trace_ready_i = ($urandom_range(0, 2) != 0);
         cfg_clear_i   = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 49) == 0) cfg_mode_i = 2'($urandom);
         tick();
      end
      cfg_clear_i = 1'b0;
      idle_inputs();
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_filter();
      test_overflow();
      test_oneshot();
      test_backpressure();
      test_midrecord_reset();
`ifdef CHERI_TRACE_CAP_EN
      test_cap();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
